tl_ram_slave: RTL and testbench
===============================

# tl_ram_slave

Single-port RAM slave on the TileLink-UL bus, attached to one `io_slaveFace` port of the bus crossbar. It accepts A-channel Get/PutFullData/PutPartialData requests and returns AccessAckData/AccessAck on the D channel. It holds one request at a time, with a registered SRAM read and a held response. The default window is one 4 KiB crossbar slot.

## Interface
Parameters:
- `BASE`, default 32'h0000_0000: byte base address of the window.
- `DEPTH`, default 1024: number of 32-bit words; must be a power of two.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `io_in_a_valid` in 1: request valid.
- `io_in_a_ready` out 1: request accepted when high with valid.
- `io_in_a_bits_opcode` in 3: 0 PutFullData, 1 PutPartialData, 4 Get.
- `io_in_a_bits_address` in 32: byte address.
- `io_in_a_bits_mask` in 4: byte lanes.
- `io_in_a_bits_data` in 32: write data.
- `io_in_d_valid` out 1: response valid.
- `io_in_d_ready` in 1: response consumed.
- `io_in_d_bits_opcode` out 3: 0 AccessAck, 1 AccessAckData.
- `io_in_d_bits_data` out 32: read data.
- `io_in_d_bits_denied` out 1: error response.

## Operation
- States: IDLE, READ, RESP. Reset value is IDLE.
- `io_in_a_ready` is 1 only in IDLE.
- Offset: off = address − BASE, in 32 bits with wrap.
- Word index: off[log2(DEPTH)+1:2]. Address bits [1:0] are ignored.
- Get accepted in IDLE:
  - issue the SRAM read, go to READ;
  - in READ, latch read data into `d_bits_data`, set d_valid, go to RESP.
- PutFull/PutPartial accepted in IDLE:
  - write lanes where mask is 1, in the acceptance cycle;
  - PutFull uses the mask as given; the slave does not force it to 4'hF;
  - go to RESP with AccessAck and data 0.
- RESP:
  - hold d_valid and all D fields stable until `d_ready`;
  - on the handshake cycle go to IDLE and clear d_valid.
- Other opcodes (2, 3, 5, 6, 7): no memory access, AccessAck with data 0. `denied` behaviour is in Configuration.
- Reset values of all outputs are 0, except `a_ready`, which is 1 one cycle after reset deasserts.
- Memory contents are not reset.
- Reset mid-operation:
  - the pending response is discarded;
  - a write already committed stays;
  - a Get in READ is dropped.

## Timing
- Get accepted at cycle N → d_valid at N+2.
- Put accepted at cycle N → d_valid at N+1.
- Write data is visible to a Get accepted at N+2 or later. No bypass is needed, since only one request is in flight.
- d_ready held high gives throughput of one Get per 3 cycles and one Put per 2 cycles.
- Back-pressure: d_ready low keeps RESP indefinitely, and a_ready stays 0.
- Simultaneous a_valid and the RESP handshake: the request is not accepted that cycle. It is accepted the next cycle, in IDLE.

## Configuration
- `TL_RAM_DENIED_EN` defined:
  - off ≥ DEPTH*4 or an unsupported opcode gives `denied`=1 with data 0;
  - the memory is not accessed;
  - response opcode follows the request: Get → AccessAckData, others → AccessAck;
  - a denied Get still goes IDLE→READ→RESP, keeping N+2 latency.
- `TL_RAM_DENIED_EN` undefined:
  - `denied` is tied 0;
  - out-of-range addresses alias modulo DEPTH words;
  - unsupported opcodes return AccessAck without a write.

## Structure
- Shared package `tl_pkg` holds:
  - opcode constants: GET=4, PUT_FULL=0, PUT_PARTIAL=1, ACCESS_ACK=0, ACCESS_ACK_DATA=1;
  - the state enum (IDLE/READ/RESP);
  - the A/D field widths.
- One sub-module, `tl_ram_array`: synchronous single-port RAM, DEPTH×32, byte write-enable, one-cycle read latency, no reset.

## Test plan
- Put addr 0x10, data 0xDEADBEEF, mask 0xF, then Get 0x10 → AccessAck at N+1, then AccessAckData 0xDEADBEEF at N+2 of the Get.
- PutPartial 0x10, data 0x11223344, mask 0x5 over 0xDEADBEEF → Get returns 0xDE22BE44.
- Get with d_ready low for 5 cycles → d_valid and data stable throughout; a_ready 0; one handshake only.
- With `TL_RAM_DENIED_EN`, Get 0x1000 (DEPTH=1024) → denied=1, data 0, memory unchanged.
- Without `TL_RAM_DENIED_EN`, Put 0x1000 then Get 0x0 → returns the written data (alias).
- Reset asserted in READ → d_valid 0 the next cycle, a_ready 1 after deassertion, no response emitted.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and types for the RAM slave slice.
package tl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] PUT_FULL        = 3'd0;
    localparam logic [OP_W-1:0] PUT_PARTIAL     = 3'd1;
    localparam logic [OP_W-1:0] GET             = 3'd4;
    localparam logic [OP_W-1:0] ACCESS_ACK      = 3'd0;
    localparam logic [OP_W-1:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } tlState;

endpackage

// File: rtl/tl_ram_array.sv
// Synchronous single-port RAM, DEPTH x 32, byte write enables, one-cycle read, no reset.
module tl_ram_array
    import tl_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clock,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     rdEn,
    input  logic [MASK_W-1:0]        wrEn,
    input  logic [DATA_W-1:0]        wrData,
    output logic [DATA_W-1:0]        rdData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(MASK_W); i++) begin
            if (wrEn[i]) begin
                mem[addr][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
        if (rdEn) begin
            rdData <= mem[addr];
        end
    end

endmodule

// File: rtl/tl_ram_slave.sv
// TileLink-UL single-port RAM slave, one request in flight (IDLE -> [READ] -> RESP).
// Define TL_RAM_DENIED_EN to deny out-of-window addresses and unsupported opcodes.
module tl_ram_slave
    import tl_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned DEPTH = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_a_valid,
    output logic              io_in_a_ready,
    input  logic [OP_W-1:0]   io_in_a_bits_opcode,
    input  logic [ADDR_W-1:0] io_in_a_bits_address,
    input  logic [MASK_W-1:0] io_in_a_bits_mask,
    input  logic [DATA_W-1:0] io_in_a_bits_data,
    output logic              io_in_d_valid,
    input  logic              io_in_d_ready,
    output logic [OP_W-1:0]   io_in_d_bits_opcode,
    output logic [DATA_W-1:0] io_in_d_bits_data,
    output logic              io_in_d_bits_denied
);

    localparam int unsigned AW = $clog2(DEPTH);

    tlState            state;
    logic              aReady;
    logic              dValid;
    logic [OP_W-1:0]   dOpcode;
    logic [DATA_W-1:0] dData;
    logic              dDenied;
    logic              pendDenied;

    logic [ADDR_W-1:0] off;
    logic [AW-1:0]     wordIdx;
    logic              isGet;
    logic              isPut;
    logic              accept;
    logic              reqDenied;
    logic [MASK_W-1:0] ramWrEn;
    logic              ramRdEn;
    logic [DATA_W-1:0] ramRdData;

    assign off     = io_in_a_bits_address - BASE;
    assign wordIdx = AW'(off >> 2);
    assign isGet   = (io_in_a_bits_opcode == GET);
    assign isPut   = (io_in_a_bits_opcode == PUT_FULL) || (io_in_a_bits_opcode == PUT_PARTIAL);
    assign accept  = io_in_a_valid && aReady;

`ifdef TL_RAM_DENIED_EN
    assign reqDenied = ((off >> 2) >= ADDR_W'(DEPTH)) || !(isGet || isPut);
`else
    // Out-of-window addresses alias onto the array; unsupported opcodes just skip the write.
    assign reqDenied = 1'b0;
`endif

    assign ramWrEn = (accept && isPut && !reqDenied) ? io_in_a_bits_mask : '0;
    assign ramRdEn = accept && isGet && !reqDenied;

    tl_ram_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clock  (clock),
        .addr   (wordIdx),
        .rdEn   (ramRdEn),
        .wrEn   (ramWrEn),
        .wrData (io_in_a_bits_data),
        .rdData (ramRdData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            aReady     <= 1'b0;
            dValid     <= 1'b0;
            dOpcode    <= '0;
            dData      <= '0;
            dDenied    <= 1'b0;
            pendDenied <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        aReady <= 1'b0;
                        if (isGet) begin
                            state      <= READ;
                            pendDenied <= reqDenied;
                        end else begin
                            state   <= RESP;
                            dValid  <= 1'b1;
                            dOpcode <= ACCESS_ACK;
                            dData   <= '0;
                            dDenied <= reqDenied;
                        end
                    end else begin
                        // Raises a_ready on the first cycle after reset release.
                        aReady <= 1'b1;
                    end
                end
                READ: begin
                    state   <= RESP;
                    dValid  <= 1'b1;
                    dOpcode <= ACCESS_ACK_DATA;
                    dData   <= pendDenied ? '0 : ramRdData;
                    dDenied <= pendDenied;
                end
                RESP: begin
                    if (io_in_d_ready) begin
                        state  <= IDLE;
                        dValid <= 1'b0;
                        aReady <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    aReady <= 1'b0;
                    dValid <= 1'b0;
                end
            endcase
        end
    end

    assign io_in_a_ready       = aReady;
    assign io_in_d_valid       = dValid;
    assign io_in_d_bits_opcode = dOpcode;
    assign io_in_d_bits_data   = dData;
    assign io_in_d_bits_denied = dDenied;

endmodule

// File: tb/tb_tl_ram_slave.sv
// Scoreboard bench for tl_ram_slave: directed requests push expected D beats, a monitor pops them.
module tb_tl_ram_slave;
    import tl_pkg::*;

`ifdef TL_RAM_DENIED_EN
    localparam logic DEN = 1'b1;
`else
    localparam logic DEN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in_a_valid = 1'b0;
    logic        io_in_a_ready;
    logic [2:0]  io_in_a_bits_opcode = '0;
    logic [31:0] io_in_a_bits_address = '0;
    logic [3:0]  io_in_a_bits_mask = '0;
    logic [31:0] io_in_a_bits_data = '0;
    logic        io_in_d_valid;
    logic        io_in_d_ready = 1'b1;
    logic [2:0]  io_in_d_bits_opcode;
    logic [31:0] io_in_d_bits_data;
    logic        io_in_d_bits_denied;

    tl_ram_slave #(
        .BASE  (32'h0000_0000),
        .DEPTH (1024)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .io_in_a_valid        (io_in_a_valid),
        .io_in_a_ready        (io_in_a_ready),
        .io_in_a_bits_opcode  (io_in_a_bits_opcode),
        .io_in_a_bits_address (io_in_a_bits_address),
        .io_in_a_bits_mask    (io_in_a_bits_mask),
        .io_in_a_bits_data    (io_in_a_bits_data),
        .io_in_d_valid        (io_in_d_valid),
        .io_in_d_ready        (io_in_d_ready),
        .io_in_d_bits_opcode  (io_in_d_bits_opcode),
        .io_in_d_bits_data    (io_in_d_bits_data),
        .io_in_d_bits_denied  (io_in_d_bits_denied)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic        denied;
        int          cyc;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    // Called #1 after a posedge; returns #1 after the acceptance edge. acc = cycle of acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [2:0] rop, input logic [31:0] rdata,
                        input logic rden, input int lat, output int acc);
        int n;
        n = 0;
        io_in_a_bits_opcode  = op;
        io_in_a_bits_address = addr;
        io_in_a_bits_mask    = mask;
        io_in_a_bits_data    = data;
        io_in_a_valid        = 1'b1;
        @(negedge clock);
        while (!io_in_a_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!io_in_a_ready) begin
            fail("a_ready timeout");
            acc = -1;
        end else begin
            acc = cyc;
            sb.push_back('{op: rop, data: rdata, denied: rden, cyc: cyc + lat});
        end
        @(posedge clock);
        #1 io_in_a_valid = 1'b0;
    endtask

    task automatic put(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic den, output int acc);
        send(op, addr, mask, data, ACCESS_ACK, 32'h0, den, 1, acc);
    endtask

    task automatic get(input logic [31:0] addr, input logic [31:0] exp, input logic den,
                       output int acc);
        send(GET, addr, 4'h0, 32'h0, ACCESS_ACK_DATA, exp, den, 2, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || io_in_d_valid) && n < 40) begin
            n++;
            @(negedge clock);
        end
        if (sb.size() != 0 || io_in_d_valid) fail("drain");
        @(posedge clock);
        #1;
    endtask

    // Monitor: latency on the rising d_valid, fields on the handshake.
    logic prevV = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            prevV = 1'b0;
        end else begin
            if (io_in_d_valid && !prevV) begin
                if (sb.size() == 0) fail("unexpected d_valid");
                else check("d_valid latency", 32'(cyc), 32'(sb[0].cyc));
            end
            if (io_in_d_valid && io_in_d_ready) begin
                if (sb.size() == 0) begin
                    fail("unexpected handshake");
                end else begin
                    expT e;
                    e = sb.pop_front();
                    check("d opcode", 32'(io_in_d_bits_opcode), 32'(e.op));
                    check("d data", io_in_d_bits_data, e.data);
                    check("d denied", 32'(io_in_d_bits_denied), 32'(e.denied));
                end
            end
            prevV = io_in_d_valid && !io_in_d_ready;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, n;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        check("reset a_ready", 32'(io_in_a_ready), 32'h0);
        check("reset d_valid", 32'(io_in_d_valid), 32'h0);
        check("reset d_opcode", 32'(io_in_d_bits_opcode), 32'h0);
        check("reset d_data", io_in_d_bits_data, 32'h0);
        check("reset d_denied", 32'(io_in_d_bits_denied), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("a_ready right after release", 32'(io_in_a_ready), 32'h0);
        @(negedge clock);
        check("a_ready one cycle after release", 32'(io_in_a_ready), 32'h1);
        @(posedge clock);
        #1;

        // Basic write/read and back-to-back throughput.
        put(PUT_FULL, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, a1);
        get(32'h10, 32'hDEAD_BEEF, 1'b0, a2);
        check("put throughput", 32'(a2 - a1), 32'd2);
        put(PUT_PARTIAL, 32'h10, 4'h5, 32'h1122_3344, 1'b0, a3);
        check("get throughput", 32'(a3 - a2), 32'd3);
        get(32'h10, 32'hDE22_BE44, 1'b0, a1);
        get(32'h13, 32'hDE22_BE44, 1'b0, a1);

        // PutFull honours a partial mask.
        put(PUT_FULL, 32'h20, 4'hF, 32'h0000_0000, 1'b0, a1);
        put(PUT_FULL, 32'h20, 4'hC, 32'hAABB_CCDD, 1'b0, a1);
        get(32'h20, 32'hAABB_0000, 1'b0, a1);

        // Unsupported opcodes: ack, data 0, no write.
        put(3'd2, 32'h10, 4'hF, 32'h0000_0055, DEN, a1);
        put(3'd5, 32'h20, 4'hF, 32'h0000_0066, DEN, a1);
        get(32'h10, 32'hDE22_BE44, 1'b0, a1);
        get(32'h20, 32'hAABB_0000, 1'b0, a1);

        // Window boundary.
        put(PUT_FULL, 32'h0, 4'hF, 32'h0102_0304, 1'b0, a1);
        put(PUT_FULL, 32'h1000, 4'hF, 32'hCAFE_F00D, DEN, a1);
`ifdef TL_RAM_DENIED_EN
        get(32'h1000, 32'h0, 1'b1, a1);
        get(32'h0, 32'h0102_0304, 1'b0, a1);
`else
        get(32'h0, 32'hCAFE_F00D, 1'b0, a1);
`endif
        drain();

        // Back-pressure: response held, no new acceptance.
        io_in_d_ready = 1'b0;
        get(32'h10, 32'hDE22_BE44, 1'b0, a1);
        n = 0;
        while (!io_in_d_valid && n < 10) begin
            n++;
            @(negedge clock);
        end
        if (!io_in_d_valid) fail("backpressure d_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall d_valid", 32'(io_in_d_valid), 32'h1);
            check("stall d_data", io_in_d_bits_data, 32'hDE22_BE44);
            check("stall a_ready", 32'(io_in_a_ready), 32'h0);
        end
        @(posedge clock);
        #1 io_in_d_ready = 1'b1;
        drain();

        // Reset while in READ: response dropped, memory kept.
        get(32'h10, 32'hDE22_BE44, 1'b0, a1);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset-in-read d_valid", 32'(io_in_d_valid), 32'h0);
        check("reset-in-read a_ready low", 32'(io_in_a_ready), 32'h0);
        @(negedge clock);
        check("reset-in-read a_ready high", 32'(io_in_a_ready), 32'h1);
        check("reset-in-read no response", 32'(io_in_d_valid), 32'h0);
        @(posedge clock);
        #1;
        get(32'h10, 32'hDE22_BE44, 1'b0, a1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
